// File: rtl/tron_tick_scheduler.sv
// tron_tick_scheduler
//   Sequences one game step per tick for two tron players and owns the single
//   plot port of the vga_adapter. After reset and on each restart it sweeps the
//   whole arena, clearing the occupancy bitmap and painting the background.
//   Each step pulses the datapaths, then checks and marks player 1 and then
//   player 2 against the arena bounds and the bitmap.
//
// Ports
//   i_clk, i_resetn          clock, asynchronous active-low reset
//   i_tick                   one-cycle game-step pulse
//   i_start                  restart request, honoured only in OVER
//   i_p1_x/y, i_p2_x/y       current head positions from the datapaths
//   o_move_en1/2             one-cycle advance strobes to the datapaths
//   o_x, o_y, o_colour       plot coordinates and colour
//   o_plot                   plot strobe
//   o_dead1/2                sticky death flags
//   o_game_over              high in OVER
//   o_busy                   high in every state except IDLE and OVER
module tron_tick_scheduler #(
   parameter int unsigned WIDTH     = 160,
   parameter int unsigned HEIGHT    = 120,
   parameter int unsigned XMIN      = 10,
   parameter int unsigned XMAX      = 150,
   parameter int unsigned YMIN      = 17,
   parameter int unsigned YMAX      = 109,
   parameter logic [2:0]  COLOUR1   = 3'b001,
   parameter logic [2:0]  COLOUR2   = 3'b100,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_tick,
   input  logic       i_start,
   input  logic [7:0] i_p1_x,
   input  logic [6:0] i_p1_y,
   input  logic [7:0] i_p2_x,
   input  logic [6:0] i_p2_y,
   output logic       o_move_en1,
   output logic       o_move_en2,
   output logic [7:0] o_x,
   output logic [6:0] o_y,
   output logic [2:0] o_colour,
   output logic       o_plot,
   output logic       o_dead1,
   output logic       o_dead2,
   output logic       o_game_over,
   output logic       o_busy
);

   localparam int unsigned CELLS = WIDTH * HEIGHT;
   localparam int unsigned AW    = $clog2(CELLS);

   localparam logic [3:0] S_CLEAR  = 4'd0;
   localparam logic [3:0] S_IDLE   = 4'd1;
   localparam logic [3:0] S_MOVE   = 4'd2;
   localparam logic [3:0] S_SETTLE = 4'd3;
   localparam logic [3:0] S_RD1    = 4'd4;
   localparam logic [3:0] S_CK1    = 4'd5;
   localparam logic [3:0] S_WR1    = 4'd6;
   localparam logic [3:0] S_RD2    = 4'd7;
   localparam logic [3:0] S_CK2    = 4'd8;
   localparam logic [3:0] S_WR2    = 4'd9;
   localparam logic [3:0] S_OVER   = 4'd10;

   logic [3:0] r_state;
   logic [7:0] r_cx;
   logic [6:0] r_cy;
   logic       r_plot;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;
   logic       r_move_en1;
   logic       r_move_en2;
   logic       r_dead1;
   logic       r_dead2;
   logic       r_game_over;
   logic       r_busy;
   logic       r_rdata;
   logic       r_bitmap [CELLS];

   logic [3:0] w_state_d;
   logic [7:0] w_cx_d;
   logic [6:0] w_cy_d;
   logic       w_plot_d;
   logic [7:0] w_x_d;
   logic [6:0] w_y_d;
   logic [2:0] w_colour_d;
   logic       w_move_en1_d;
   logic       w_move_en2_d;
   logic       w_dead1_d;
   logic       w_dead2_d;
   logic       w_p1_in;
   logic       w_p2_in;
   logic       w_heads_eq;
   logic [7:0] w_ax;
   logic [6:0] w_ay;
   logic [AW-1:0] w_addr;
   logic       w_re;
   logic       w_we;
   logic       w_wdata;

   assign w_p1_in = (32'(i_p1_x) >= XMIN) && (32'(i_p1_x) <= XMAX) &&
                    (32'(i_p1_y) >= YMIN) && (32'(i_p1_y) <= YMAX);
   assign w_p2_in = (32'(i_p2_x) >= XMIN) && (32'(i_p2_x) <= XMAX) &&
                    (32'(i_p2_y) >= YMIN) && (32'(i_p2_y) <= YMAX);
   assign w_heads_eq = (i_p1_x == i_p2_x) && (i_p1_y == i_p2_y);

   // Bitmap port address: sweep counters while clearing, else the head under test.
   always_comb begin
      w_ax = r_cx;
      w_ay = r_cy;
      if (r_state inside {S_RD2, S_CK2, S_WR2}) begin
         w_ax = i_p2_x;
         w_ay = i_p2_y;
      end else if (r_state != S_CLEAR) begin
         w_ax = i_p1_x;
         w_ay = i_p1_y;
      end
      w_addr  = AW'(w_ay) * AW'(WIDTH) + AW'(w_ax);
      // Out-of-bounds heads never touch the bitmap, so the address stays in range.
      w_re    = ((r_state == S_RD1) && w_p1_in) || ((r_state == S_RD2) && w_p2_in);
      w_we    = (r_state == S_CLEAR) || ((r_state == S_WR1) && !r_dead1) ||
                ((r_state == S_WR2) && !r_dead2);
      w_wdata = (r_state != S_CLEAR);
   end

   always_ff @(posedge i_clk) begin
      if (w_we) r_bitmap[w_addr] <= w_wdata;
      if (w_re) r_rdata <= r_bitmap[w_addr];
   end

   // Outputs are registered: each output register holds the value for the state
   // being entered, so decisions made in CKn are visible during WRn.
   always_comb begin
      w_state_d    = r_state;
      w_cx_d       = r_cx;
      w_cy_d       = r_cy;
      w_plot_d     = 1'b0;
      w_x_d        = r_x;
      w_y_d        = r_y;
      w_colour_d   = r_colour;
      w_move_en1_d = 1'b0;
      w_move_en2_d = 1'b0;
      w_dead1_d    = r_dead1;
      w_dead2_d    = r_dead2;
      case (r_state)
         S_CLEAR: begin
            w_plot_d   = 1'b1;
            w_x_d      = r_cx;
            w_y_d      = r_cy;
            w_colour_d = BG_COLOUR;
            w_dead1_d  = 1'b0;
            w_dead2_d  = 1'b0;
            if (r_cx == 8'(WIDTH - 1)) begin
               w_cx_d = 8'd0;
               if (r_cy == 7'(HEIGHT - 1)) begin
                  w_cy_d    = 7'd0;
                  w_state_d = S_IDLE;
               end else begin
                  w_cy_d = r_cy + 7'd1;
               end
            end else begin
               w_cx_d = r_cx + 8'd1;
            end
         end
         S_IDLE: begin
            if (i_tick) begin
               w_state_d    = S_MOVE;
               w_move_en1_d = !r_dead1;
               w_move_en2_d = !r_dead2;
            end
         end
         S_MOVE:   w_state_d = S_SETTLE;
         S_SETTLE: w_state_d = S_RD1;
         S_RD1:    w_state_d = S_CK1;
         S_CK1: begin
            w_state_d = S_WR1;
            // r_rdata is only meaningful when in bounds; !w_p1_in masks it.
            w_dead1_d = r_dead1 | !w_p1_in | r_rdata | w_heads_eq;
            w_dead2_d = r_dead2 | w_heads_eq;
            if (!w_dead1_d) begin
               w_plot_d   = 1'b1;
               w_x_d      = i_p1_x;
               w_y_d      = i_p1_y;
               w_colour_d = COLOUR1;
            end
         end
         S_WR1: w_state_d = S_RD2;
         S_RD2: w_state_d = S_CK2;
         S_CK2: begin
            w_state_d = S_WR2;
            w_dead2_d = r_dead2 | !w_p2_in | r_rdata | w_heads_eq;
            if (!w_dead2_d) begin
               w_plot_d   = 1'b1;
               w_x_d      = i_p2_x;
               w_y_d      = i_p2_y;
               w_colour_d = COLOUR2;
            end
         end
         S_WR2: w_state_d = (r_dead1 || r_dead2) ? S_OVER : S_IDLE;
         S_OVER: begin
            if (i_start) begin
               w_state_d = S_CLEAR;
               w_cx_d    = 8'd0;
               w_cy_d    = 7'd0;
               w_dead1_d = 1'b0;
               w_dead2_d = 1'b0;
            end
         end
         default: begin
            w_state_d = S_CLEAR;
            w_cx_d    = 8'd0;
            w_cy_d    = 7'd0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= S_CLEAR;
         r_cx        <= 8'd0;
         r_cy        <= 7'd0;
         r_plot      <= 1'b0;
         r_x         <= 8'd0;
         r_y         <= 7'd0;
         r_colour    <= BG_COLOUR;
         r_move_en1  <= 1'b0;
         r_move_en2  <= 1'b0;
         r_dead1     <= 1'b0;
         r_dead2     <= 1'b0;
         r_game_over <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_state     <= w_state_d;
         r_cx        <= w_cx_d;
         r_cy        <= w_cy_d;
         r_plot      <= w_plot_d;
         r_x         <= w_x_d;
         r_y         <= w_y_d;
         r_colour    <= w_colour_d;
         r_move_en1  <= w_move_en1_d;
         r_move_en2  <= w_move_en2_d;
         r_dead1     <= w_dead1_d;
         r_dead2     <= w_dead2_d;
         r_game_over <= (w_state_d == S_OVER);
         r_busy      <= (w_state_d != S_IDLE) && (w_state_d != S_OVER);
      end
   end

   assign o_move_en1  = r_move_en1;
   assign o_move_en2  = r_move_en2;
   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_colour    = r_colour;
   assign o_plot      = r_plot;
   assign o_dead1     = r_dead1;
   assign o_dead2     = r_dead2;
   assign o_game_over = r_game_over;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_tron_tick_scheduler.sv
module tb_tron_tick_scheduler;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [7:0] p1_x = 8'd0;
   logic [6:0] p1_y = 7'd0;
   logic [7:0] p2_x = 8'd0;
   logic [6:0] p2_y = 7'd0;
   logic       move_en1, move_en2, plot, dead1, dead2, game_over, busy;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   int checks = 0;
   int errors = 0;

   // Reference model: arena occupancy and the last p1 head sent.
   bit         occ [160][120];
   logic [7:0] last_x1;
   logic [6:0] last_y1;

   tron_tick_scheduler dut (
      .i_clk      (clk),
      .i_resetn   (resetn),
      .i_tick     (tick),
      .i_start    (start),
      .i_p1_x     (p1_x),
      .i_p1_y     (p1_y),
      .i_p2_x     (p2_x),
      .i_p2_y     (p2_y),
      .o_move_en1 (move_en1),
      .o_move_en2 (move_en2),
      .o_x        (x),
      .o_y        (y),
      .o_colour   (colour),
      .o_plot     (plot),
      .o_dead1    (dead1),
      .o_dead2    (dead2),
      .o_game_over(game_over),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic bit in_b(input logic [7:0] ax, input logic [6:0] ay);
      return (ax >= 8'd10) && (ax <= 8'd150) && (ay >= 7'd17) && (ay <= 7'd109);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) occ[i][j] = 1'b0;
   endtask

   // Expects a sweep to begin within a few cycles; follows it cell by cell.
   task automatic run_clear(input string tag);
      int w = 0;
      int bad = 0;
      int first_bad = -1;
      while (plot !== 1'b1 && w < 6) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (plot !== 1'b1) begin
         errors++;
         $display("FAIL %s_start: plot=%b required 1 within 6 cycles", tag, plot);
         return;
      end
      checks++;
      if ({x, y} !== 15'd0) begin
         errors++;
         $display("FAIL %s_first: x=%0d y=%0d required 0 0", tag, x, y);
      end
      for (int i = 0; i < 19200; i++) begin
         if ({plot, x, y, colour} !== {1'b1, 8'(i % 160), 7'(i / 160), 3'b000}) begin
            if (bad == 0) first_bad = i;
            bad++;
         end
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s_seq: %0d bad cells (first at index %0d) required 0", tag, bad,
                  first_bad);
      end
      checks++;
      if ({plot, busy, dead1, dead2, game_over} !== 5'b00000) begin
         errors++;
         $display("FAIL %s_end: plot,busy,dead1,dead2,over=%b required 00000", tag,
                  {plot, busy, dead1, dead2, game_over});
      end
      model_clear();
   endtask

   // One tick-driven step: model predicts deaths and plots, bench checks per cycle.
   task automatic do_step(input logic [7:0] ax1, input logic [6:0] ay1,
                          input logic [7:0] ax2, input logic [6:0] ay2,
                          input bit tick_wr1, input string tag);
      bit eq, d1, d2;
      logic [3:0] exp_v;
      eq = (ax1 == ax2) && (ay1 == ay2);
      d1 = !in_b(ax1, ay1) || eq;
      if (!d1 && occ[ax1][ay1]) d1 = 1'b1;
      if (!d1) occ[ax1][ay1] = 1'b1;
      d2 = !in_b(ax2, ay2) || eq;
      if (!d2 && occ[ax2][ay2]) d2 = 1'b1;
      if (!d2) occ[ax2][ay2] = 1'b1;
      last_x1 = ax1;
      last_y1 = ay1;

      @(negedge clk);
      p1_x = ax1; p1_y = ay1; p2_x = ax2; p2_y = ay2;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         exp_v = {k == 1, k == 1, (k == 5 && !d1) || (k == 8 && !d2), k <= 8};
         checks++;
         if ({move_en1, move_en2, plot, busy} !== exp_v) begin
            errors++;
            $display("FAIL %s_T+%0d: move1,move2,plot,busy=%b required %b", tag, k,
                     {move_en1, move_en2, plot, busy}, exp_v);
         end
         if (k == 5 && !d1) begin
            checks++;
            if ({x, y, colour} !== {ax1, ay1, 3'b001}) begin
               errors++;
               $display("FAIL %s_p1plot: x=%0d y=%0d c=%b required %0d %0d 001", tag, x, y,
                        colour, ax1, ay1);
            end
         end
         if (k == 8 && !d2) begin
            checks++;
            if ({x, y, colour} !== {ax2, ay2, 3'b100}) begin
               errors++;
               $display("FAIL %s_p2plot: x=%0d y=%0d c=%b required %0d %0d 100", tag, x, y,
                        colour, ax2, ay2);
            end
         end
         if (tick_wr1 && k == 5) tick = 1'b1;
         if (k == 6) tick = 1'b0;
         if (k < 9) @(negedge clk);
      end
      checks++;
      if ({dead1, dead2, game_over} !== {d1, d2, d1 | d2}) begin
         errors++;
         $display("FAIL %s_flags: dead1,dead2,over=%b required %b", tag,
                  {dead1, dead2, game_over}, {d1, d2, d1 | d2});
      end
   endtask

   task automatic pick_fresh(output logic [7:0] ox, output logic [6:0] oy,
                             input logic [7:0] ax, input logic [6:0] ay);
      for (int n = 0; n < 1000; n++) begin
         ox = 8'($urandom_range(150, 10));
         oy = 7'($urandom_range(109, 17));
         if (!occ[ox][oy] && !(ox == ax && oy == ay)) break;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({plot, x, y, colour, move_en1, move_en2, dead1, dead2, game_over, busy} !==
          {1'b0, 8'd0, 7'd0, 3'd0, 5'b00000, 1'b1}) begin
         errors++;
         $display("FAIL reset: plot=%b x=%0d y=%0d c=%b me=%b%b d=%b%b over=%b busy=%b",
                  plot, x, y, colour, move_en1, move_en2, dead1, dead2, game_over, busy);
      end
   endtask

   task automatic test_reset_mid_clear();
      resetn = 1'b1;
      @(negedge clk);
      repeat (120) @(negedge clk);
      checks++;
      if ({plot, x, y} !== {1'b1, 8'd120, 7'd0}) begin
         errors++;
         $display("FAIL midclear_pos: plot=%b x=%0d y=%0d required 1 120 0", plot, x, y);
      end
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if ({plot, x, y} !== {1'b0, 8'd0, 7'd0}) begin
         errors++;
         $display("FAIL midclear_reset: plot=%b x=%0d y=%0d required 0 0 0", plot, x, y);
      end
      resetn = 1'b1;
      run_clear("clear_after_reset");
   endtask

   task automatic test_tick_dropped();
      do_step(8'd40, 7'd40, 8'd41, 7'd41, 1'b1, "tick_wr1");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({move_en1, move_en2, busy} !== 3'b000) begin
            errors++;
            $display("FAIL tick_wr1_after%0d: move1,move2,busy=%b required 000", k,
                     {move_en1, move_en2, busy});
         end
      end
   endtask

   task automatic test_start_ignored();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({busy, plot} !== 2'b00) begin
            errors++;
            $display("FAIL start_idle%0d: busy,plot=%b required 00", k, {busy, plot});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_random_alive();
      logic [7:0] ax1, ax2;
      logic [6:0] ay1, ay2;
      for (int s = 0; s < 20; s++) begin
         pick_fresh(ax1, ay1, 8'd0, 7'd0);
         pick_fresh(ax2, ay2, ax1, ay1);
         do_step(ax1, ay1, ax2, ay2, 1'b0, "random");
      end
   endtask

   task automatic test_hold();
      logic [7:0] ax2;
      logic [6:0] ay2;
      pick_fresh(ax2, ay2, last_x1, last_y1);
      do_step(last_x1, last_y1, ax2, ay2, 1'b0, "hold");
   endtask

   task automatic test_over();
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({move_en1, move_en2, plot, busy, game_over} !== 5'b00001) begin
            errors++;
            $display("FAIL over_tick%0d: move1,move2,plot,busy,over=%b required 00001", k,
                     {move_en1, move_en2, plot, busy, game_over});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_restart(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      run_clear(tag);
   endtask

   task automatic test_boundary_death(input logic [7:0] ax1, input logic [6:0] ay1,
                                      input string tag);
      logic [7:0] ax2;
      logic [6:0] ay2;
      pick_fresh(ax2, ay2, ax1, ay1);
      do_step(ax1, ay1, ax2, ay2, 1'b0, tag);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_reset_mid_clear();
      do_step(8'd25, 7'd25, 8'd100, 7'd100, 1'b0, "basic");
      do_step(8'd150, 7'd60, 8'd100, 7'd101, 1'b0, "x150");
      do_step(8'd30, 7'd17, 8'd101, 7'd101, 1'b0, "y17");
      do_step(8'd10, 7'd109, 8'd150, 7'd17, 1'b0, "corners");
      test_tick_dropped();
      test_start_ignored();
      test_random_alive();
      test_hold();
      test_over();
      test_restart("restart1");
      test_boundary_death(8'd151, 7'd50, "x151");
      test_restart("restart2");
      test_boundary_death(8'd40, 7'd16, "y16");
      test_restart("restart3");
      do_step(8'd60, 7'd60, 8'd60, 7'd60, 1'b0, "headon");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tron_tick_scheduler.md
Name: tron_tick_scheduler

Overview:
- Sequences one game step per tick for both tron players and owns the single vga_adapter plot port.
- Pulses the datapaths to advance, then checks each new head position against the arena bounds and an internal occupancy bitmap.
- Marks and plots each surviving head, and flags deaths.
- Clears the arena (bitmap and screen) after reset and on each restart.

Parameters:
- WIDTH, 160, screen width in cells
- HEIGHT, 120, screen height in cells
- XMIN, 10, lowest legal x (inclusive)
- XMAX, 150, highest legal x (inclusive)
- YMIN, 17, lowest legal y (inclusive)
- YMAX, 109, highest legal y (inclusive)
- COLOUR1, 3'b001, player 1 trail colour
- COLOUR2, 3'b100, player 2 trail colour
- BG_COLOUR, 3'b000, clear colour

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-step pulse from the rate divider
- start  in  1  restart request, honoured only in OVER
- p1_x  in  8  player 1 head x from datapath
- p1_y  in  7  player 1 head y
- p2_x  in  8  player 2 head x
- p2_y  in  7  player 2 head y
- move_en1  out  1  one-cycle advance strobe to datapath 1
- move_en2  out  1  one-cycle advance strobe to datapath 2
- x  out  8  plot x to vga_adapter
- y  out  7  plot y to vga_adapter
- colour  out  3  plot colour
- plot  out  1  plot strobe
- dead1  out  1  sticky player 1 death flag
- dead2  out  1  sticky player 2 death flag
- game_over  out  1  high in OVER
- busy  out  1  high in every state except IDLE and OVER

Behaviour:
- Reset (async, resetn=0):
  - state=CLEAR, sweep counters cleared.
  - plot=0, x=0, y=0, colour=BG_COLOUR.
  - move_en1=move_en2=0, dead1=dead2=0, game_over=0.
- Bitmap: WIDTH*HEIGHT x 1 bit, address y*WIDTH+x. One read/write port; read data valid the cycle after the address is presented.
- All outputs are registered.
- CLEAR:
  - One cell per cycle, x inner loop 0..WIDTH-1, y outer loop 0..HEIGHT-1.
  - Writes 0 to the bitmap and drives plot=1 with colour=BG_COLOUR at that cell.
  - First plot is (0,0); last is (WIDTH-1,HEIGHT-1). Total WIDTH*HEIGHT cycles, then IDLE.
  - dead1, dead2 and game_over are cleared on entry.
  - tick is ignored.
- IDLE: tick=1 moves to MOVE. Otherwise stay.
- MOVE (1 cycle): move_en1 = !dead1, move_en2 = !dead2.
- SETTLE (1 cycle): datapath registers update.
- RD1: present the p1 address.
- CK1: player 1 dies if p1 is out of bounds, or bitmap bit=1, or (p1_x,p1_y)==(p2_x,p2_y).
  - A head-on collision kills both players: dead1 and dead2 are set in CK1.
- WR1:
  - If player 1 is alive, write 1 and drive plot=1 at (p1_x,p1_y) with COLOUR1.
  - Otherwise plot=0 and no write.
- RD2, CK2, WR2: same as RD1/CK1/WR1 for player 2 with COLOUR2.
  - CK2 sees the bit written in WR1.
  - Out-of-bounds cells never access the bitmap.
- After WR2:
  - If dead1 or dead2 is set, go to OVER. Else go to IDLE.
  - plot is 0 in every cycle except the CLEAR sweep and the WR cycles.
- Timing: tick sampled high in IDLE at cycle T gives:
  - move_en high at T+1.
  - p1 plot at T+5.
  - p2 plot at T+8.
  - Back in IDLE at T+9.
- A tick while not in IDLE is dropped; no queueing.
- OVER: game_over=1, no plotting, tick ignored. start=1 moves to CLEAR. start in any other state is ignored.
- Bounds are inclusive: x=XMIN..XMAX and y=YMIN..YMAX are legal. Coordinates wrapping to 255/127 fall out of bounds and are therefore dead.
- resetn asserted mid-sequence (CLEAR, a WR cycle, anything else) aborts immediately to reset values. The sweep restarts from (0,0).

Test Plan:
- Release reset -> plot=1 for exactly 19200 consecutive cycles, colour=000; first (0,0), last (159,119); then busy=0.
- Players at (25,25) and (100,100), one tick at T:
  - move_en1=move_en2=1 only at T+1.
  - plot (25,25,001) at T+5 and (100,100,100) at T+8.
  - dead1=dead2=0, state back to IDLE.
- Hold p1 at (25,25) across two ticks -> second tick sets dead1 at CK1, no p1 plot, game_over=1 after WR2. p2 is still plotted in that same step.
- Boundary:
  - p1_x=150 -> alive and plotted.
  - p1_x=151 -> dead1.
  - p1_y=17 -> alive.
  - p1_y=16 -> dead1.
- Both heads at (60,60) on the same tick -> dead1=dead2=1, no plots, game_over=1.
- Tick asserted during WR1 -> ignored, no extra move_en.
- start in OVER -> full 19200-cycle clear, dead flags cleared.
- resetn pulsed mid-CLEAR -> sweep restarts at (0,0).
